// File: rtl/match_timer.sv
// Round countdown timer: IDLE/RUN/PAUSE/DONE FSM with a registered BCD split and a low-time warning.
// Defining TIMER_WARN_BLINK_EN makes warn blink at 0.5 Hz inside the warning zone instead of holding steady.
module match_timer #(
    parameter int WARN_SECS = 5,
    parameter int MAX_CLAMP = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic [7:0] max_time,
    output logic [7:0] time_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       running,
    output logic       time_up,
    output logic       expired,
    output logic       warn
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [7:0] CLAMP = 8'(MAX_CLAMP);
    localparam logic [7:0] WARN  = 8'(WARN_SECS);

    state_t     state, state_nxt;
    logic [7:0] left_nxt;
    logic [7:0] load_val;
    logic       expired_nxt;
    logic       zone_nxt;
    logic       warn_nxt;

    function automatic logic in_zone(input state_t s, input logic [7:0] t);
        return ((s == RUN) || (s == PAUSE)) && (t != 8'd0) && (t <= WARN);
    endfunction

    assign load_val = (max_time > CLAMP) ? CLAMP : max_time;

    // start outranks everything; in RUN a held pause masks a coincident tick.
    always_comb begin
        state_nxt   = state;
        left_nxt    = time_left;
        expired_nxt = 1'b0;
        if (start) begin
            left_nxt = load_val;
            if (load_val == 8'd0) begin
                state_nxt   = DONE;
                expired_nxt = 1'b1;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        if (time_left <= 8'd1) begin
                            left_nxt    = 8'd0;
                            state_nxt   = DONE;
                            expired_nxt = 1'b1;
                        end else begin
                            left_nxt = time_left - 8'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) state_nxt = RUN;
                end
                DONE: begin
                    left_nxt = 8'd0;
                end
                default: ;
            endcase
        end
    end

    assign zone_nxt = in_zone(state_nxt, left_nxt);

`ifdef TIMER_WARN_BLINK_EN
    logic zone_cur;
    logic dec;

    assign zone_cur = in_zone(state, time_left);
    assign dec      = (state == RUN) && !start && !pause && tick && (time_left > 8'd1);

    // Entering the zone (or restarting inside it) lights warn; each decrement inside flips it.
    always_comb begin
        warn_nxt = warn;
        if (!zone_nxt)
            warn_nxt = 1'b0;
        else if (start || !zone_cur)
            warn_nxt = 1'b1;
        else if (dec)
            warn_nxt = ~warn;
    end
`else
    assign warn_nxt = zone_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            time_left <= 8'd0;
            bcd_tens  <= 4'd0;
            bcd_ones  <= 4'd0;
            running   <= 1'b0;
            time_up   <= 1'b0;
            expired   <= 1'b0;
            warn      <= 1'b0;
        end else begin
            state     <= state_nxt;
            time_left <= left_nxt;
            // time_left never exceeds 99, so both digits stay within 0..9.
            bcd_tens  <= 4'(time_left / 8'd10);
            bcd_ones  <= 4'(time_left % 8'd10);
            running   <= (state_nxt == RUN);
            time_up   <= (state_nxt == DONE);
            expired   <= expired_nxt;
            warn      <= warn_nxt;
        end
    end

endmodule

// File: tb/tb_match_timer.sv
// Bench for match_timer: directed vector table plus randomized cycles against a behavioural model.
module tb_match_timer;

    localparam int W = 5;
    localparam int C = 99;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk = 1'b0;
    logic       reset, tick, start, pause;
    logic [7:0] max_time;
    logic [7:0] time_left;
    logic [3:0] bcd_tens, bcd_ones;
    logic       running, time_up, expired, warn;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int   m_st = S_IDLE;
    int   m_left = 0;
    int   m_bt = 0, m_bo = 0;
    logic m_exp = 1'b0;
    logic m_warn = 1'b0;

    match_timer dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
        .max_time(max_time), .time_left(time_left), .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones), .running(running), .time_up(time_up),
        .expired(expired), .warn(warn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, s, t, p;
        logic [7:0] mt;
        int         e_left;
        logic       e_run, e_up, e_exp, e_ws, e_wb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic t, logic p, int mt,
                                int el, logic er, logic eu, logic ee, logic ws, logic wb);
        vec_t v;
        v.r = r; v.s = s; v.t = t; v.p = p; v.mt = 8'(mt);
        v.e_left = el; v.e_run = er; v.e_up = eu; v.e_exp = ee; v.e_ws = ws; v.e_wb = wb;
        return v;
    endfunction

    function automatic logic zone(int st, int left);
        return (st == S_RUN || st == S_PAUSE) && left > 0 && left <= W;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, s, t, p, input int mt);
        int   prev, c;
        logic zb, za, dec;
        prev  = m_left;
        m_exp = 1'b0;
        dec   = 1'b0;
        if (r) begin
            m_st = S_IDLE; m_left = 0; m_warn = 1'b0; m_bt = 0; m_bo = 0;
        end else begin
            zb = zone(m_st, m_left);
            if (s) begin
                c      = (mt > C) ? C : mt;
                m_left = c;
                m_st   = (c == 0) ? S_DONE : S_RUN;
                m_exp  = (c == 0);
            end else if (m_st == S_RUN && p) begin
                m_st = S_PAUSE;
            end else if (m_st == S_RUN && t) begin
                if (m_left == 1) begin
                    m_left = 0; m_st = S_DONE; m_exp = 1'b1;
                end else begin
                    m_left = m_left - 1; dec = 1'b1;
                end
            end else if (m_st == S_PAUSE && !p) begin
                m_st = S_RUN;
            end
            m_bt = prev / 10;
            m_bo = prev % 10;
            za   = zone(m_st, m_left);
`ifdef TIMER_WARN_BLINK_EN
            if (!za)            m_warn = 1'b0;
            else if (s || !zb)  m_warn = 1'b1;
            else if (dec)       m_warn = ~m_warn;
`else
            m_warn = za;
`endif
        end
    endtask

    // Drive one cycle from the falling edge, step the model at the rising edge, compare at the next fall.
    task automatic cyc(input logic r, s, t, p, input logic [7:0] mt);
        reset = r; start = s; tick = t; pause = p; max_time = mt;
        @(posedge clk);
        model_step(r, s, t, p, int'(mt));
        @(negedge clk);
        chk("time_left", time_left, m_left);
        chk("bcd_tens", bcd_tens, m_bt);
        chk("bcd_ones", bcd_ones, m_bo);
        chk("running", running, (m_st == S_RUN));
        chk("time_up", time_up, (m_st == S_DONE));
        chk("expired", expired, m_exp);
        chk("warn", warn, m_warn);
    endtask

    initial begin
        logic p_lvl;
        reset = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; max_time = 8'd0;

        //             r  s  t  p  mt   left run up exp ws wb
        tbl.push_back(mk(1, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,    0, 0, 0, 0, 0, 0));   // tick in IDLE ignored
        tbl.push_back(mk(0, 1, 0, 0, 3,    3, 1, 0, 0, 1, 1));   // normal round
        tbl.push_back(mk(0, 0, 1, 0, 0,    2, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,    1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0,    0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0,    0, 0, 1, 0, 0, 0));   // DONE holds, digits 0,0
        tbl.push_back(mk(0, 1, 0, 0, 150, 99, 1, 0, 0, 0, 0));   // clamp
        tbl.push_back(mk(0, 0, 0, 0, 150, 99, 1, 0, 0, 0, 0));   // digits 9,9
        tbl.push_back(mk(0, 0, 1, 0, 3,   98, 1, 0, 0, 0, 0));   // max_time change ignored
        tbl.push_back(mk(0, 0, 0, 0, 3,   98, 1, 0, 0, 0, 0));   // digits 9,8
        tbl.push_back(mk(0, 1, 1, 0, 7,    7, 1, 0, 0, 0, 0));   // start beats tick
        tbl.push_back(mk(0, 0, 1, 0, 7,    6, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 7,    5, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 7,    4, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 7,    3, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 7,    3, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 7,    3, 0, 0, 0, 1, 1));   // pause in zone holds warn
        tbl.push_back(mk(0, 0, 1, 1, 7,    3, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 7,    3, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 7,    2, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 7,    1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 7,    0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0,    0, 0, 1, 1, 0, 0));   // zero load from DONE
        tbl.push_back(mk(0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 10,  10, 1, 0, 0, 0, 0));   // pause round
        tbl.push_back(mk(0, 0, 0, 1, 10,  10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 10,  10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 10,  10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 10,  10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 10,  10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 10,   9, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 5,    5, 1, 0, 0, 1, 1));   // reset mid-round
        tbl.push_back(mk(0, 0, 1, 0, 5,    4, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 5,    0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 5,    0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1,    1, 1, 0, 0, 1, 1));   // reset on expiry edge
        tbl.push_back(mk(1, 0, 1, 0, 1,    0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].p, tbl[i].mt);
            chk("tbl_left", time_left, tbl[i].e_left);
            chk("tbl_running", running, tbl[i].e_run);
            chk("tbl_time_up", time_up, tbl[i].e_up);
            chk("tbl_expired", expired, tbl[i].e_exp);
`ifdef TIMER_WARN_BLINK_EN
            chk("tbl_warn", warn, tbl[i].e_wb);
`else
            chk("tbl_warn", warn, tbl[i].e_ws);
`endif
        end

        p_lvl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic r, s, t;
            logic [7:0] mt;
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 24) == 0);
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 11) == 0) p_lvl = ~p_lvl;
            mt = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
            cyc(r, s, t, p_lvl, mt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
